adc_spi_reader: RTL
===================

ADC_SPI_READER -- requirements
Module: adc_spi_reader

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 24, meaning fpga_clock cycles per SCLK half-period (84 MHz / 48 = 1.75 MHz SCLK); legal range 1..255.
REQ-002 SHALL have parameter FRAME_BITS, default 16, meaning SCLK cycles per transfer.
REQ-003 SHALL have port fpga_clock, input, 1 bit: system clock.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit: request one transfer.
REQ-006 SHALL have port cmd_in, input, FRAME_BITS bits: word shifted out on MOSI, MSB first.
REQ-007 SHALL have port busy, output, 1 bit: transfer or CS gap in progress.
REQ-008 SHALL have port data_out, output, FRAME_BITS bits: last word received on MISO.
REQ-009 SHALL have port data_valid, output, 1 bit: one-cycle pulse when data_out updates.
REQ-010 SHALL have port spi_cs_out, output, 1 bit: chip select, active-low.
REQ-011 SHALL have port spi_clock_out, output, 1 bit: SCLK, idle low (SPI mode 0).
REQ-012 SHALL have port spi_mosi_out, output, 1 bit: master-out data.
REQ-013 SHALL have port spi_miso_in, input, 1 bit: slave-out data from external ADC.

Function
REQ-014 SHALL implement FSM states IDLE, SETUP, SHIFT_LOW, SHIFT_HIGH, HOLD, GAP, all outputs registered.
REQ-015 IDLE: start=1 sampled at edge N SHALL latch cmd_in, assert busy, drive spi_cs_out low and go to SETUP.
REQ-016 start while busy=1 SHALL be ignored; it is neither queued nor latched.
REQ-017 SETUP SHALL last HALF_PERIOD cycles with spi_mosi_out = latched cmd bit FRAME_BITS-1 and SCLK low.
REQ-018 SHIFT_LOW/SHIFT_HIGH SHALL alternate, each HALF_PERIOD cycles, FRAME_BITS times; a half-period counter and a bit counter drive the transitions.
REQ-019 On entry to SHIFT_HIGH (SCLK rising), spi_miso_in SHALL be sampled into the receive shift register (LSB in, shift left).
REQ-020 On each SHIFT_HIGH to SHIFT_LOW transition (SCLK falling), spi_mosi_out SHALL advance to the next lower cmd bit; after the last bit, spi_mosi_out SHALL be 0.
REQ-021 After the FRAME_BITS-th high half, SCLK SHALL return low and HOLD SHALL last HALF_PERIOD cycles with CS still low.
REQ-022 At HOLD exit, at edge N + (2*FRAME_BITS+2)*HALF_PERIOD, the FSM SHALL set spi_cs_out high, load data_out and pulse data_valid for exactly one cycle.
REQ-023 GAP SHALL hold CS high for HALF_PERIOD cycles, then clear busy and enter IDLE; a start on the first IDLE cycle SHALL be accepted.
REQ-024 data_out SHALL hold its value until the next data_valid.
REQ-025 Counter widths SHALL be 8 bits (half-period) and $clog2(FRAME_BITS)+1 (bits); counters SHALL never wrap within a frame.

Reset
REQ-026 Reset, including mid-frame, SHALL immediately force spi_cs_out=1, spi_clock_out=0, spi_mosi_out=0, busy=0, data_valid=0, data_out=0, FSM=IDLE and counters to 0.
REQ-027 A partially received word SHALL be discarded on reset, and no data_valid SHALL follow reset release.

Structure
REQ-028 FRAME_BITS default, HALF_PERIOD default and FSM state encodings SHALL live in the shared constants package used by the DAC/ADC SPI blocks.
REQ-029 A single sub-module sclk_phase_gen (half-period counter emitting rise/fall strobes) is natural; the FSM and shift registers SHALL stay in adc_spi_reader.

Verification (HALF_PERIOD=2, FRAME_BITS=16, bench ADC model)
REQ-030 Single transfer: start at edge N with cmd_in=16'hC000 and model returning 16'hA5C3 -> model receives 16'hC000, data_out=16'hA5C3, data_valid one cycle at edge N+68, busy low at N+70.
REQ-031 SCLK check: during REQ-030 -> exactly 16 rising edges, 4-cycle period, CS low for 68 cycles, MOSI stable across every rising edge.
REQ-032 Busy start: start re-pulsed at N+10 and N+40 with cmd 16'hFFFF -> ignored; frame completes with 16'hC000 sent.
REQ-033 Back-to-back: start held high continuously -> frames start at N and N+70, each with CS high for exactly 2 cycles between them.
REQ-034 Reset mid-frame: reset at N+30 -> CS=1, SCLK=0, busy=0 the same cycle; no data_valid; the next transfer returns a fresh 16'h0F0F correctly.
REQ-035 Boundary data: model returns 16'h0000, then 16'hFFFF -> data_out matches each value, with exactly one data_valid per frame.

Source files
------------

// File: rtl/adc_spi_reader_pkg.sv
// Shared constants and FSM encoding for the DAC/ADC SPI blocks.
package adc_spi_reader_pkg;

  localparam int unsigned SPI_FRAME_BITS  = 16;
  localparam int unsigned SPI_HALF_PERIOD = 24;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SETUP      = 3'd1,
    SHIFT_LOW  = 3'd2,
    SHIFT_HIGH = 3'd3,
    HOLD       = 3'd4,
    GAP        = 3'd5
  } spi_state_t;

endpackage

// File: rtl/adc_spi_reader_sclk_phase_gen.sv
// Half-period counter for the SPI master; strobes the end of each SCLK half.
module sclk_phase_gen
  import adc_spi_reader_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = SPI_HALF_PERIOD
) (
  input  logic fpga_clock,
  input  logic reset,
  input  logic enable,
  input  logic sclk_high,
  output logic half_done_c,
  output logic rise_c,
  output logic fall_c
);

  localparam logic [7:0] LAST_COUNT = 8'(HALF_PERIOD - 1);

  logic [7:0] half_cnt;

  assign half_done_c = enable && (half_cnt == LAST_COUNT);
  assign rise_c      = half_done_c && !sclk_high;
  assign fall_c      = half_done_c && sclk_high;

  // Held at zero while idle so every frame starts on a fresh half-period.
  always_ff @(posedge fpga_clock or posedge reset) begin
    if (reset)
      half_cnt <= 8'd0;
    else if (!enable || half_done_c)
      half_cnt <= 8'd0;
    else
      half_cnt <= half_cnt + 8'd1;
  end

endmodule

// File: rtl/adc_spi_reader.sv
// SPI mode-0 master that shifts a command word out and reads one ADC word back.
module adc_spi_reader
  import adc_spi_reader_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = SPI_HALF_PERIOD,
  parameter int unsigned FRAME_BITS  = SPI_FRAME_BITS
) (
  input  logic                  fpga_clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] cmd_in,
  output logic                  busy,
  output logic [FRAME_BITS-1:0] data_out,
  output logic                  data_valid,
  output logic                  spi_cs_out,
  output logic                  spi_clock_out,
  output logic                  spi_mosi_out,
  input  logic                  spi_miso_in
);

  localparam int unsigned BIT_W = $clog2(FRAME_BITS) + 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);

  spi_state_t             state;
  logic [BIT_W-1:0]       bit_cnt;
  logic [FRAME_BITS-2:0]  tx_reg;
  logic [FRAME_BITS-1:0]  rx_reg;
  logic                   half_done_c;
  logic                   rise_c;
  logic                   fall_c;
  logic                   accept_c;

  sclk_phase_gen #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_phase (
    .fpga_clock (fpga_clock),
    .reset      (reset),
    .enable     (state != IDLE),
    .sclk_high  (spi_clock_out),
    .half_done_c(half_done_c),
    .rise_c     (rise_c),
    .fall_c     (fall_c)
  );

  // A start arriving as the gap expires is taken immediately, giving back-to-back frames.
  assign accept_c = start && ((state == IDLE) || ((state == GAP) && half_done_c));

  always_ff @(posedge fpga_clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      tx_reg        <= '0;
      rx_reg        <= '0;
      busy          <= 1'b0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      spi_cs_out    <= 1'b1;
      spi_clock_out <= 1'b0;
      spi_mosi_out  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (accept_c) begin
        state        <= SETUP;
        bit_cnt      <= '0;
        tx_reg       <= cmd_in[FRAME_BITS-2:0];
        spi_mosi_out <= cmd_in[FRAME_BITS-1];
        spi_cs_out   <= 1'b0;
        busy         <= 1'b1;
      end else begin
        case (state)
          IDLE: ;
          SETUP: begin
            if (half_done_c) state <= SHIFT_LOW;
          end
          SHIFT_LOW: begin
            if (rise_c) begin
              state         <= SHIFT_HIGH;
              spi_clock_out <= 1'b1;
              rx_reg        <= {rx_reg[FRAME_BITS-2:0], spi_miso_in};
            end
          end
          SHIFT_HIGH: begin
            if (fall_c) begin
              spi_clock_out <= 1'b0;
              if (bit_cnt == LAST_BIT) begin
                state        <= HOLD;
                spi_mosi_out <= 1'b0;
              end else begin
                state        <= SHIFT_LOW;
                bit_cnt      <= bit_cnt + BIT_W'(1);
                spi_mosi_out <= tx_reg[FRAME_BITS-2];
                tx_reg       <= tx_reg << 1;
              end
            end
          end
          HOLD: begin
            if (half_done_c) begin
              state      <= GAP;
              spi_cs_out <= 1'b1;
              data_out   <= rx_reg;
              data_valid <= 1'b1;
            end
          end
          GAP: begin
            if (half_done_c) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
